// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial transmitter: FSM encodings,
// frame overhead and counter sizing.
package even_parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Start, parity and stop bits surround the payload.
  localparam int FRAME_OVERHEAD = 3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/even_parity_gen.sv
// Combinational even-parity generator: XOR-reduce of the payload word.
module even_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Serial transmitter: start bit, DATA_W payload bits LSB first, even parity,
// stop bit; each bit held CLKS_PER_BIT cycles on a registered line.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BIT_W  = cnt_width(DATA_W);
  localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic              parity_w;
  logic              armed;
  logic              bit_end;

  even_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
    .data   (tx_data),
    .parity (parity_w)
  );

  assign bit_end = (baud_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      // The edge that releases reset never accepts a word.
      armed   <= 1'b1;
      tx_done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready && armed) begin
            state     <= START;
            shift_q   <= tx_data;
            parity_q  <= parity_w;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            tx_serial <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              state     <= PARITY;
              tx_serial <= parity_q;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx_serial <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            tx_serial <= 1'b1;
            tx_done   <= (CLKS_PER_BIT == 1);
          end
        end
        STOP: begin
          // tx_done is registered, so raise it one cycle ahead of the last stop cycle.
          if (bit_end) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end else if (baud_cnt == LAST_TICK - 1'b1) begin
            tx_done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench for even_parity_serial_tx: per-cycle line comparison
// against a frame model, plus a receiver-side even-parity loopback.
module tb_even_parity_serial_tx;
  import even_parity_pkg::*;

  localparam int DW    = 8;
  localparam int C     = 4;
  localparam int FRAME = (DW + FRAME_OVERHEAD) * C;
  localparam int CAPN  = 2 * FRAME + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_serial, tx_busy, tx_done;

  int vectors = 0;
  int miscompares = 0;

  logic cap_ser  [1:CAPN];
  logic cap_busy [1:CAPN];
  logic cap_done [1:CAPN];
  logic cap_rdy  [1:CAPN];

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  // Expected line level k cycles after acceptance (k=1 is the first start-bit cycle).
  function automatic logic exp_line(input logic [DW-1:0] w, input int k);
    int b;
    if (k < 1 || k > FRAME) return 1'b1;
    b = (k - 1) / C;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (b == DW + 1) return (($countones(w) % 2) == 1);
    return 1'b1;
  endfunction

  // Receiver-side even-parity check: 1 means an odd number of ones was received.
  function automatic logic checker_err(input logic [DW-1:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) == 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [DW-1:0] w, input logic [DW-1:0] next_w,
                         input logic keep_valid, input int ncyc, input int pulse_at);
    int guard;
    guard = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: tx_ready=%b, required 1", tx_ready);
    end
    tick();
    tx_data  = next_w;
    tx_valid = keep_valid;
    for (int k = 1; k <= ncyc; k++) begin
      cap_ser[k]  = tx_serial;
      cap_busy[k] = tx_busy;
      cap_done[k] = tx_done;
      cap_rdy[k]  = tx_ready;
      if (k == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = ~w;
      end else if (pulse_at > 0 && k == pulse_at + 1) begin
        tx_valid = 1'b0;
      end
      if (k < ncyc) tick();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tick();
    tick();
    vectors++; if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL reset_serial: got %b expected 1", tx_serial); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_frames();
    logic [DW-1:0] words [$];
    logic          exp_par [4];
    logic [DW-1:0] w;
    words   = '{8'h00, 8'h01, 8'hA5, 8'hFF};
    exp_par = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) words.push_back(DW'($urandom));
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      capture(w, DW'($urandom), 1'b0, FRAME + 1, 0);
      for (int k = 1; k <= FRAME + 1; k++) begin
        vectors++;
        if (cap_ser[k] !== exp_line(w, k)) begin
          miscompares++;
          $display("FAIL frame_serial w=%h k=%0d: got %b expected %b", w, k, cap_ser[k], exp_line(w, k));
        end
        vectors++;
        if (cap_busy[k] !== (k <= FRAME)) begin
          miscompares++;
          $display("FAIL frame_busy w=%h k=%0d: got %b expected %b", w, k, cap_busy[k], k <= FRAME);
        end
        vectors++;
        if (cap_done[k] !== (k == FRAME)) begin
          miscompares++;
          $display("FAIL frame_done w=%h k=%0d: got %b expected %b", w, k, cap_done[k], k == FRAME);
        end
        vectors++;
        if (cap_rdy[k] !== (k > FRAME)) begin
          miscompares++;
          $display("FAIL frame_ready w=%h k=%0d: got %b expected %b", w, k, cap_rdy[k], k > FRAME);
        end
      end
      if (i < 4) begin
        vectors++;
        if (cap_ser[(DW + 1) * C + 1] !== exp_par[i]) begin
          miscompares++;
          $display("FAIL parity_bit w=%h: got %b expected %b", w, cap_ser[(DW + 1) * C + 1], exp_par[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   ndone;
    logic e;
    ndone = 0;
    capture(8'h3C, 8'h7F, 1'b1, 2 * FRAME + 1, 0);
    tx_valid = 1'b0;
    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      e = (k <= FRAME) ? exp_line(8'h3C, k) : exp_line(8'h7F, k - FRAME - 1);
      vectors++;
      if (cap_ser[k] !== e) begin
        miscompares++;
        $display("FAIL b2b_serial k=%0d: got %b expected %b", k, cap_ser[k], e);
      end
      if (cap_done[k] === 1'b1) ndone++;
    end
    vectors++;
    if (ndone !== 2 || cap_done[FRAME] !== 1'b1 || cap_done[2 * FRAME + 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d pulses expected 2 at k=%0d and k=%0d", ndone, FRAME, 2 * FRAME + 1);
    end
    vectors++;
    if (cap_rdy[FRAME + 1] !== 1'b1 || cap_busy[FRAME + 1] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: ready=%b busy=%b expected 1 0", cap_rdy[FRAME + 1], cap_busy[FRAME + 1]);
    end
    tick();
    tick();
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_third: busy got %b expected 0", tx_busy);
    end
  endtask

  task automatic test_ignore_busy();
    logic [DW-1:0] w;
    int            ndone;
    w = DW'($urandom);
    ndone = 0;
    capture(w, ~w, 1'b0, FRAME + 6, 20);
    for (int k = 1; k <= FRAME + 6; k++) begin
      vectors++;
      if (cap_ser[k] !== exp_line(w, k)) begin
        miscompares++;
        $display("FAIL busy_serial w=%h k=%0d: got %b expected %b", w, k, cap_ser[k], exp_line(w, k));
      end
      vectors++;
      if (cap_busy[k] !== (k <= FRAME)) begin
        miscompares++;
        $display("FAIL busy_flag w=%h k=%0d: got %b expected %b", w, k, cap_busy[k], k <= FRAME);
      end
      if (cap_done[k] === 1'b1) ndone++;
    end
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL busy_done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_reset_mid_frame();
    capture(8'h5A, 8'h00, 1'b0, 16, 0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL midrst_serial: got %b expected 1", tx_serial); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", tx_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (tx_done !== 1'b0 || tx_serial !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst_hold: done=%b serial=%b expected 0 1", tx_done, tx_serial);
      end
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL postrst_idle: done=%b busy=%b expected 0 0", tx_done, tx_busy);
      end
    end
    capture(8'h81, 8'h00, 1'b0, FRAME + 1, 0);
    for (int k = 1; k <= FRAME + 1; k++) begin
      vectors++;
      if (cap_ser[k] !== exp_line(8'h81, k) || cap_done[k] !== (k == FRAME)) begin
        miscompares++;
        $display("FAIL postrst_frame k=%0d: serial=%b done=%b expected %b %b",
                 k, cap_ser[k], cap_done[k], exp_line(8'h81, k), k == FRAME);
      end
    end
    vectors++;
    if (cap_ser[(DW + 1) * C + 1] !== 1'b0) begin
      miscompares++;
      $display("FAIL postrst_parity: got %b expected 0", cap_ser[(DW + 1) * C + 1]);
    end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] w, rx;
    logic          st, par, sp;
    for (int n = 0; n < 256; n++) begin
      w = DW'(n);
      capture(w, 8'h00, 1'b0, FRAME + 1, 0);
      st = cap_ser[C / 2 + 1];
      for (int b = 0; b < DW; b++) rx[b] = cap_ser[(b + 1) * C + C / 2 + 1];
      par = cap_ser[(DW + 1) * C + C / 2 + 1];
      sp  = cap_ser[(DW + 2) * C + C / 2 + 1];
      vectors++;
      if (checker_err(rx, par) !== 1'b0) begin
        miscompares++;
        $display("FAIL loop_parity_err w=%h: got 1 expected 0 (rx=%h par=%b)", w, rx, par);
      end
      vectors++;
      if (rx !== w) begin
        miscompares++;
        $display("FAIL loop_data: got %h expected %h", rx, w);
      end
      vectors++;
      if (st !== 1'b0 || sp !== 1'b1) begin
        miscompares++;
        $display("FAIL loop_framing w=%h: start=%b stop=%b expected 0 1", w, st, sp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
